// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX forwarding, load-use stalls, D-miss freeze, redirect drain, sticky halt.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit #(
  parameter int unsigned NFWD     = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SELW     = $clog2(NFWD + 1)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [4:0]             rs,
  input  logic [4:0]             rt,
  input  logic [4:0]             ex_wsel,
  input  logic                   ex_memread,
  input  logic [5*NFWD-1:0]      fwd_wsel,
  input  logic [NFWD-1:0]        fwd_regwr,
  input  logic [1:0]             PCSrc,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   mem_dren,
  input  logic                   mem_dwen,
  input  logic                   halt,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic [SELW-1:0]        fwd_sel_a,
  output logic [SELW-1:0]        fwd_sel_b,
  output logic                   halted,
  output logic [31:0]            perf_stall,
  output logic [31:0]            perf_flush
);

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_LDSTALL = 3'd1;
  localparam logic [2:0] ST_MEMWAIT = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [2:0] LD_CNT = 3'(LOAD_LAT - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] ret_q, ret_d;
  logic [2:0] eff_state;

  logic freeze, load_use, redirect;
  logic pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n;
  logic ifid_flush_n, idex_flush_n;
  logic [SELW-1:0] sel_a_n, sel_b_n;

  assign freeze   = (mem_dren | mem_dwen) & ~dhit;
  assign load_use = ex_memread & (ex_wsel != 5'd0) & ((ex_wsel == rs) | (ex_wsel == rt));

  // Scan oldest to youngest so the youngest matching source wins.
  always_comb begin
    sel_a_n = '0;
    sel_b_n = '0;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_regwr[i] && (fwd_wsel[5*i +: 5] != 5'd0)) begin
        if (fwd_wsel[5*i +: 5] == rs) sel_a_n = SELW'(i + 1);
        if (fwd_wsel[5*i +: 5] == rt) sel_b_n = SELW'(i + 1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      ret_q   <= ST_RUN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  // Leaving MEMWAIT evaluates the saved state's behaviour in the dhit cycle itself.
  assign eff_state = (state_q == ST_MEMWAIT) ? ret_q : state_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ret_d        = ret_q;
    pc_en_n      = 1'b0;
    ifid_en_n    = 1'b0;
    idex_en_n    = 1'b0;
    exmem_en_n   = 1'b0;
    memwb_en_n   = 1'b0;
    ifid_flush_n = 1'b0;
    idex_flush_n = 1'b0;
    redirect     = 1'b0;
    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (freeze) begin
      state_d = ST_MEMWAIT;
      if (state_q != ST_MEMWAIT) ret_d = state_q;
    end else if (halt) begin
      state_d = ST_HALT;
    end else begin
      state_d = eff_state;
      case (eff_state)
        ST_RUN: begin
          idex_en_n  = 1'b1;
          exmem_en_n = 1'b1;
          memwb_en_n = 1'b1;
          if (PCSrc != 2'd0) begin
            redirect     = 1'b1;
            pc_en_n      = 1'b1;
            ifid_en_n    = 1'b1;
            ifid_flush_n = 1'b1;
            idex_flush_n = 1'b1;
            if (!ihit) state_d = ST_DRAIN;
          end else if (load_use) begin
            idex_flush_n = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = ST_LDSTALL;
              cnt_d   = LD_CNT;
            end
          end else begin
            ifid_en_n    = 1'b1;
            pc_en_n      = ihit;
            ifid_flush_n = ~ihit;
          end
        end
        ST_LDSTALL: begin
          idex_en_n    = 1'b1;
          exmem_en_n   = 1'b1;
          memwb_en_n   = 1'b1;
          idex_flush_n = 1'b1;
          cnt_d        = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end
        end
        ST_DRAIN: begin
          ifid_en_n    = 1'b1;
          idex_en_n    = 1'b1;
          exmem_en_n   = 1'b1;
          memwb_en_n   = 1'b1;
          ifid_flush_n = 1'b1;
          if (ihit) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Outputs are forced quiet asynchronously while reset is held.
  assign pc_en      = nRST & pc_en_n;
  assign ifid_en    = nRST & ifid_en_n;
  assign idex_en    = nRST & idex_en_n;
  assign exmem_en   = nRST & exmem_en_n;
  assign memwb_en   = nRST & memwb_en_n;
  assign ifid_flush = nRST & ifid_flush_n;
  assign idex_flush = nRST & idex_flush_n;
  assign fwd_sel_a  = nRST ? sel_a_n : '0;
  assign fwd_sel_b  = nRST ? sel_b_n : '0;
  assign halted     = nRST & (state_q == ST_HALT);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (!pc_en && !halted && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  logic unused_perf;
  assign unused_perf = redirect;
  assign perf_stall  = 32'd0;
  assign perf_flush  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (NFWD=2, LOAD_LAT=2): vector table plus multi-cycle sequences.
module tb_hazard_ctrl_unit;

  typedef struct {
    logic [4:0] rs, rt, ex_wsel;
    logic       memread;
    logic [9:0] fwsel;
    logic [1:0] regwr, pcsrc;
    logic       ihit, dhit, dren, dwen, hlt;
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [1:0] fl;   // {ifid, idex}
    logic [1:0] sa, sb;
    logic       hd;
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [4:0] rs, rt, ex_wsel;
  logic       ex_memread;
  logic [9:0] fwd_wsel;
  logic [1:0] fwd_regwr, PCSrc;
  logic       ihit, dhit, mem_dren, mem_dwen, halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic [31:0] perf_stall, perf_flush;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  vec_t vecs[10];
  vec_t v;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(.NFWD(2), .LOAD_LAT(2)) dut (
    .CLK(CLK), .nRST(nRST), .rs(rs), .rt(rt), .ex_wsel(ex_wsel), .ex_memread(ex_memread),
    .fwd_wsel(fwd_wsel), .fwd_regwr(fwd_regwr), .PCSrc(PCSrc), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .halt(halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .halted(halted), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  function automatic vec_t idle();
    vec_t r;
    r.rs = 5'd0; r.rt = 5'd0; r.ex_wsel = 5'd0; r.memread = 1'b0;
    r.fwsel = 10'd0; r.regwr = 2'b00; r.pcsrc = 2'd0;
    r.ihit = 1'b1; r.dhit = 1'b0; r.dren = 1'b0; r.dwen = 1'b0; r.hlt = 1'b0;
    r.en = 5'b11111; r.fl = 2'b00; r.sa = 2'd0; r.sb = 2'd0; r.hd = 1'b0;
    return r;
  endfunction

  function automatic vec_t quiet(input vec_t a);
    vec_t r = a;
    r.en = 5'b00000; r.fl = 2'b00; r.sa = 2'd0; r.sb = 2'd0; r.hd = 1'b0;
    return r;
  endfunction

  task automatic drive(input vec_t a);
    rs = a.rs; rt = a.rt; ex_wsel = a.ex_wsel; ex_memread = a.memread;
    fwd_wsel = a.fwsel; fwd_regwr = a.regwr; PCSrc = a.pcsrc;
    ihit = a.ihit; dhit = a.dhit; mem_dren = a.dren; mem_dwen = a.dwen; halt = a.hlt;
  endtask

  task automatic check(input string name, input vec_t a, input bit count_perf);
    logic [13:0] got, want;
    got  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, fwd_sel_a, fwd_sel_b, halted};
    want = {a.en, a.fl, a.sa, a.sb, a.hd};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got en=%b fl=%b sa=%0d sb=%0d halted=%b, want en=%b fl=%b sa=%0d sb=%0d halted=%b",
               name, got[13:9], got[8:7], got[6:5], got[4:3], got[0],
               a.en, a.fl, a.sa, a.sb, a.hd);
    end
    if (count_perf) begin
      if (!a.en[4] && !a.hd) exp_stall++;
      if (a.fl == 2'b11) exp_flush++;
    end
  endtask

  task automatic check_perf(input string name);
    int ws, wf;
`ifdef HAZARD_PERF_EN
    ws = exp_stall; wf = exp_flush;
`else
    ws = 0; wf = 0;
`endif
    total++;
    if (perf_stall !== 32'(ws) || perf_flush !== 32'(wf)) begin
      bad++;
      $display("FAIL %s: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
               name, perf_stall, perf_flush, ws, wf);
    end
  endtask

  task automatic step(input string name, input vec_t a);
    drive(a);
    @(negedge CLK);
    check(name, a, 1'b1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state with forwarding stimulus applied: everything must be quiet.
    v = idle(); v.rs = 5'd5; v.fwsel = {5'd5, 5'd5}; v.regwr = 2'b11;
    drive(v);
    #12;
    check("reset_outputs", quiet(v), 1'b0);
    check_perf("reset_perf");
    @(posedge CLK); #1;
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) vecs[i] = idle();
    vecs[1].rs = 5'd5; vecs[1].fwsel = {5'd5, 5'd5}; vecs[1].regwr = 2'b11; vecs[1].sa = 2'd1;
    vecs[2].rs = 5'd0; vecs[2].fwsel = {5'd5, 5'd5}; vecs[2].regwr = 2'b11;
    vecs[3].rs = 5'd5; vecs[3].fwsel = {5'd5, 5'd3}; vecs[3].regwr = 2'b11; vecs[3].sa = 2'd2;
    vecs[4].rt = 5'd7; vecs[4].fwsel = {5'd7, 5'd7}; vecs[4].regwr = 2'b10; vecs[4].sb = 2'd2;
    vecs[5].rs = 5'd5; vecs[5].fwsel = {5'd5, 5'd5}; vecs[5].regwr = 2'b00;
    vecs[6].ihit = 1'b0; vecs[6].en = 5'b01111; vecs[6].fl = 2'b10;
    vecs[7].dwen = 1'b1; vecs[7].dhit = 1'b1;
    vecs[8].memread = 1'b1; vecs[8].ex_wsel = 5'd0;
    vecs[9].ex_wsel = 5'd4; vecs[9].rs = 5'd4;
    for (int i = 0; i < 10; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Load-use, LOAD_LAT=2: exactly two stall cycles.
    v = idle(); v.memread = 1'b1; v.ex_wsel = 5'd9; v.rt = 5'd9; v.en = 5'b00111; v.fl = 2'b01;
    step("ld_c1", v);
    v = idle(); v.en = 5'b00111; v.fl = 2'b01;
    step("ld_c2", v);
    step("ld_done", idle());

    // Freeze in the middle of a load-use stall.
    v = idle(); v.memread = 1'b1; v.ex_wsel = 5'd9; v.rs = 5'd9; v.en = 5'b00111; v.fl = 2'b01;
    step("fz_ld", v);
    v = idle(); v.dren = 1'b1; v.dhit = 1'b0; v.en = 5'b00000;
    for (int i = 0; i < 3; i++) step($sformatf("fz_hold%0d", i), v);
    v = idle(); v.dren = 1'b1; v.dhit = 1'b1; v.en = 5'b00111; v.fl = 2'b01;
    step("fz_resume", v);
    step("fz_done", idle());

    // Redirect during an I-miss, then drain the wrong-path fetch.
    v = idle(); v.pcsrc = 2'd1; v.ihit = 1'b0; v.fl = 2'b11;
    step("rd_cycle", v);
    v = idle(); v.ihit = 1'b0; v.en = 5'b01111; v.fl = 2'b10;
    step("rd_drain_miss", v);
    v = idle(); v.en = 5'b01111; v.fl = 2'b10;
    step("rd_drain_hit", v);
    step("rd_done", idle());

    // Redirect beats load-use.
    v = idle(); v.pcsrc = 2'd2; v.memread = 1'b1; v.ex_wsel = 5'd9; v.rt = 5'd9; v.fl = 2'b11;
    step("rd_over_ld", v);
    step("rd_over_ld_after", idle());

    // Freeze beats redirect; redirect re-evaluated on dhit.
    v = idle(); v.pcsrc = 2'd1; v.dren = 1'b1; v.en = 5'b00000;
    step("fz_rd_hold", v);
    v = idle(); v.pcsrc = 2'd1; v.dren = 1'b1; v.dhit = 1'b1; v.fl = 2'b11;
    step("fz_rd_resume", v);
    step("fz_rd_done", idle());

    check_perf("perf_counts");

    // Reset released mid-drain restarts cleanly in RUN.
    v = idle(); v.pcsrc = 2'd1; v.ihit = 1'b0; v.fl = 2'b11;
    step("rst_drain_rd", v);
    nRST = 1'b0; #2; nRST = 1'b1;
    exp_stall = 0; exp_flush = 0;
    step("rst_drain_after", idle());

    // Halt wins over redirect and is sticky.
    v = idle(); v.hlt = 1'b1; v.pcsrc = 2'd1; v.en = 5'b00000;
    step("halt_cycle", v);
    v = idle(); v.en = 5'b00000; v.hd = 1'b1;
    step("halt_sticky0", v);
    v.pcsrc = 2'd1; v.dren = 1'b1;
    step("halt_sticky1", v);
    check_perf("perf_after_halt");

    // Asynchronous reset clears halted without a clock edge.
    drive(idle());
    nRST = 1'b0;
    #2;
    check("halt_async_rst", quiet(idle()), 1'b0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_stall = 0; exp_flush = 0;
    step("after_rst_run", idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
